// File: rtl/node_route_sequencer.sv
// Line-following route sequencer.
// Walks a 16-entry route table, one entry per detected node: stop at the
// node, then go straight, turn left/right until the line is re-acquired,
// or finish. A turn that never re-acquires the line ends in FAULT.
//
//   state  | meaning
//   IDLE   | stopped, route table writable, waiting for start
//   FOLLOW | tracking the line, watching for the next node
//   PAUSE  | stopped on a node for PAUSE_CYCLES
//   TURN   | turning toward dir until the centre sensor sees the line again
//   DONE   | route finished, stopped until reset or a new start edge
//   FAULT  | turn timed out, stopped until reset or a new start edge
module node_route_sequencer #(
  parameter int unsigned THRESH       = 500,
  parameter int unsigned PAUSE_CYCLES = 3_125_000,
  parameter int unsigned TURN_MIN     = 6_250_000,
  parameter int unsigned TURN_MAX     = 25_000_000,
  parameter int unsigned HOLDOFF      = 6_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] left_sensor,
  input  logic [11:0] center_sensor,
  input  logic [11:0] right_sensor,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [1:0]  cfg_dir,
  output logic [1:0]  cmd,
  output logic [4:0]  node_count,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_TURN   = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [1:0] DIR_STRAIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT     = 2'd1;
  localparam logic [1:0] DIR_END      = 2'd3;

  localparam logic [1:0] CMD_FOLLOW = 2'd0;
  localparam logic [1:0] CMD_LEFT   = 2'd1;
  localparam logic [1:0] CMD_RIGHT  = 2'd2;
  localparam logic [1:0] CMD_STOP   = 2'd3;

  // A zero-length interval still lasts one cycle.
  localparam logic [31:0] THRESH_W     = 32'(THRESH);
  localparam logic [31:0] PAUSE_EFF    = (PAUSE_CYCLES == 0) ? 32'd1 : 32'(PAUSE_CYCLES);
  localparam logic [31:0] TURN_MIN_EFF = (TURN_MIN == 0)     ? 32'd1 : 32'(TURN_MIN);
  localparam logic [31:0] TURN_MAX_EFF = (TURN_MAX == 0)     ? 32'd1 : 32'(TURN_MAX);
  localparam logic [31:0] HOLDOFF_EFF  = (HOLDOFF == 0)      ? 32'd1 : 32'(HOLDOFF);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  dir_q, dir_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] holdoff_q, holdoff_d;
  logic        start_q;
  logic [1:0]  cmd_q, cmd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        fault_q, fault_d;
  logic [1:0]  table_q [16];

  logic [31:0] left_w, center_w, right_w;
  logic        left_on, center_on, right_on;
  logic        node_hit, line_ok, start_rise;

  assign left_w   = {20'd0, left_sensor};
  assign center_w = {20'd0, center_sensor};
  assign right_w  = {20'd0, right_sensor};

  assign left_on   = left_w   > THRESH_W;
  assign center_on = center_w > THRESH_W;
  assign right_on  = right_w  > THRESH_W;

  assign node_hit   = left_on & center_on & right_on;
  assign line_ok    = center_on & ~left_on & ~right_on;
  assign start_rise = start & ~start_q;

  // Route table: reset to all STRAIGHT, writable only while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) table_q[i] <= DIR_STRAIGHT;
    end else if (cfg_we && state_q == ST_IDLE) begin
      table_q[cfg_addr] <= cfg_dir;
    end
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= 4'd0;
      cnt_q     <= 5'd0;
      dir_q     <= DIR_STRAIGHT;
      timer_q   <= 32'd0;
      holdoff_q <= 32'd0;
      start_q   <= 1'b0;
      cmd_q     <= CMD_STOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      timer_q   <= timer_d;
      holdoff_q <= holdoff_d;
      start_q   <= start;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they
  // register together with it.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    holdoff_d = holdoff_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FOLLOW;
          idx_d     = 4'd0;
          cnt_d     = 5'd0;
          timer_d   = 32'd0;
          holdoff_d = 32'd0;
        end
      end

      ST_FOLLOW: begin
        // Blanking after a node keeps a wide node marker from counting twice.
        if (holdoff_q != 32'd0) begin
          holdoff_d = holdoff_q - 32'd1;
        end else if (node_hit) begin
          state_d = ST_PAUSE;
          if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
          dir_d   = table_q[idx_q];
          timer_d = PAUSE_EFF - 32'd1;
        end
      end

      ST_PAUSE: begin
        if (timer_q != 32'd0) begin
          timer_d = timer_q - 32'd1;
        end else if (dir_q == DIR_END || idx_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 4'd1;
          if (dir_q == DIR_STRAIGHT) begin
            state_d   = ST_FOLLOW;
            holdoff_d = HOLDOFF_EFF;
          end else begin
            state_d = ST_TURN;
            timer_d = 32'd0;
          end
        end
      end

      ST_TURN: begin
        // Re-acquire wins over timeout when both happen in the same cycle.
        if (timer_q >= TURN_MIN_EFF && line_ok) begin
          state_d   = ST_FOLLOW;
          holdoff_d = HOLDOFF_EFF;
        end else if (timer_q + 32'd1 >= TURN_MAX_EFF) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_DONE, ST_FAULT: begin
        if (start_rise) begin
          state_d   = ST_FOLLOW;
          idx_d     = 4'd0;
          cnt_d     = 5'd0;
          timer_d   = 32'd0;
          holdoff_d = 32'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state.
  always_comb begin
    cmd_d   = CMD_STOP;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_d)
      ST_FOLLOW: begin
        cmd_d  = CMD_FOLLOW;
        busy_d = 1'b1;
      end
      ST_PAUSE: busy_d = 1'b1;
      ST_TURN: begin
        cmd_d  = (dir_d == DIR_LEFT) ? CMD_LEFT : CMD_RIGHT;
        busy_d = 1'b1;
      end
      ST_DONE:  done_d  = 1'b1;
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign cmd        = cmd_q;
  assign node_count = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_node_route_sequencer.sv
// Directed bench for node_route_sequencer with short timing parameters.
module tb_node_route_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] left_sensor, center_sensor, right_sensor;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_dir;
  logic [1:0]  cmd;
  logic [4:0]  node_count;
  logic        busy, done, fault;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [11:0] l;
    logic [11:0] c;
    logic [11:0] r;
    logic        hit;
  } vec_t;

  vec_t vecs[8];

  node_route_sequencer #(
    .THRESH(500), .PAUSE_CYCLES(4), .TURN_MIN(8), .TURN_MAX(20), .HOLDOFF(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .left_sensor(left_sensor), .center_sensor(center_sensor), .right_sensor(right_sensor),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_dir(cfg_dir),
    .cmd(cmd), .node_count(node_count), .busy(busy), .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_sens(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    left_sensor = l; center_sensor = c; right_sensor = r;
  endtask

  task automatic neutral(); set_sens(12'd0, 12'd600, 12'd0); endtask
  task automatic blank();   set_sens(12'd0, 12'd0, 12'd0);   endtask
  task automatic hit();     set_sens(12'd600, 12'd600, 12'd600); endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_dir = 2'd0;
    blank();
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic write_entry(input logic [3:0] a, input logic [1:0] d);
    cfg_addr = a; cfg_dir = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  // Counts consecutive observed cycles with cmd == v (bounded).
  task automatic count_while(input logic [1:0] v, output int n);
    n = 0;
    while (cmd === v && n < 64) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int exp_cnt;

    vecs[0] = '{12'd501,  12'd501,  12'd501,  1'b1};
    vecs[1] = '{12'd500,  12'd501,  12'd501,  1'b0};
    vecs[2] = '{12'd501,  12'd500,  12'd501,  1'b0};
    vecs[3] = '{12'd501,  12'd501,  12'd500,  1'b0};
    vecs[4] = '{12'd4095, 12'd4095, 12'd4095, 1'b1};
    vecs[5] = '{12'd0,    12'd4095, 12'd0,    1'b0};
    vecs[6] = '{12'd2048, 12'd2048, 12'd2048, 1'b1};
    vecs[7] = '{12'd500,  12'd500,  12'd500,  1'b0};

    // Route {LEFT, END}: pause, turn, re-acquire, holdoff, finish, restart.
    do_reset();
    check("rst_cmd", cmd, 3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    check("rst_count", node_count, 0);
    write_entry(4'd0, 2'd1);
    write_entry(4'd1, 2'd3);
    neutral();
    start = 1'b1;
    tick();
    check("s1_follow_cmd", cmd, 0);
    check("s1_busy", busy, 1);
    hit(); tick(); blank();
    check("s1_count1", node_count, 1);
    count_while(2'd3, n);
    check("s1_pause_len", n, 4);
    check("s1_turn_left", cmd, 1);
    repeat (10) tick();
    check("s1_turn_c10", cmd, 1);
    neutral(); tick();
    check("s1_reacquire", cmd, 0);
    hit(); tick(); neutral();
    check("s1_holdoff_ignore", node_count, 1);
    repeat (8) tick();
    hit(); tick(); neutral();
    check("s1_count2", node_count, 2);
    n = 0;
    while (done !== 1'b1 && n < 40) begin n++; tick(); end
    check("s1_done", done, 1);
    check("s1_done_cmd", cmd, 3);
    check("s1_done_busy", busy, 0);
    check("s1_done_count", node_count, 2);
    repeat (3) tick();
    check("s1_held_start", done, 1);
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("s1_restart_busy", busy, 1);
    check("s1_restart_done", done, 0);
    check("s1_restart_count", node_count, 0);
    check("s1_restart_cmd", cmd, 0);

    // Threshold vectors on an all-STRAIGHT route.
    do_reset();
    neutral();
    start = 1'b1;
    tick();
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (12) tick();
      set_sens(vecs[i].l, vecs[i].c, vecs[i].r);
      tick();
      neutral();
      if (vecs[i].hit) exp_cnt++;
      check($sformatf("vec%0d_count", i), node_count, exp_cnt);
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].hit ? 3 : 0);
    end

    // Holdoff after a straight node, and table writes outside IDLE.
    do_reset();
    neutral();
    start = 1'b1;
    tick();
    set_sens(12'h800, 12'h800, 12'h800); tick(); neutral();
    check("s2_count1", node_count, 1);
    count_while(2'd3, n);
    check("s2_pause_len", n, 4);
    hit(); repeat (3) tick(); neutral(); tick();
    check("s2_holdoff_count", node_count, 1);
    check("s2_holdoff_cmd", cmd, 0);
    write_entry(4'd1, 2'd3);
    repeat (8) tick();
    set_sens(12'h800, 12'h800, 12'h800); repeat (3) tick(); neutral();
    check("s2_count2", node_count, 2);
    repeat (5) tick();
    check("s2_not_done", done, 0);
    check("s2_straight_cmd", cmd, 0);

    // Route {RIGHT}, line never re-acquired: timeout into FAULT.
    do_reset();
    write_entry(4'd0, 2'd2);
    neutral();
    start = 1'b1;
    tick();
    hit(); tick(); blank();
    count_while(2'd3, n);
    check("s3_pause_len", n, 4);
    count_while(2'd2, n);
    check("s3_right_len", n, 20);
    check("s3_fault", fault, 1);
    check("s3_fault_cmd", cmd, 3);
    check("s3_fault_busy", busy, 0);
    repeat (3) tick();
    check("s3_fault_hold", fault, 1);

    // Early line_ok in a turn waits for the minimum turn time.
    do_reset();
    write_entry(4'd0, 2'd1);
    neutral();
    start = 1'b1;
    tick();
    hit(); tick(); blank();
    count_while(2'd3, n);
    repeat (3) tick();
    neutral();
    count_while(2'd1, n);
    check("s4_left_from_c3", n, 6);
    check("s4_exit_cmd", cmd, 0);

    // Asynchronous reset in the middle of a turn, then a fresh run.
    do_reset();
    write_entry(4'd0, 2'd1);
    neutral();
    start = 1'b1;
    tick();
    hit(); tick(); blank();
    count_while(2'd3, n);
    repeat (2) tick();
    check("s5_in_turn", cmd, 1);
    #2;
    rst = 1'b0;
    #1;
    check("s5_async_cmd", cmd, 3);
    check("s5_async_busy", busy, 0);
    check("s5_async_count", node_count, 0);
    tick();
    rst = 1'b1;
    neutral();
    tick();
    check("s5_rerun_busy", busy, 1);
    check("s5_rerun_cmd", cmd, 0);
    hit(); tick(); neutral();
    check("s5_rerun_count", node_count, 1);
    count_while(2'd3, n);
    check("s5_rerun_pause", n, 4);
    check("s5_table_reset", cmd, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
